// File: rtl/register_file.sv
// 16 x 18-bit register file: two combinational read ports, one write port,
// and an external input bus continuously loaded into register IN_REG.
module register_file #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4,
  parameter int IN_REG = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data_in,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2
);

  localparam int Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] InIdx = ADDR_W'(IN_REG);

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];

  // Input bus loads first so a port write to IN_REG overrides it.
  always_comb begin
    regs_d = regs_q;
    regs_d[InIdx] = write_data_in;
    if (write_enable) begin
      regs_d[write_addr] = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign data_out1 = regs_q[read_addr1];
  assign data_out2 = regs_q[read_addr2];

endmodule

// File: tb/tb_register_file.sv
// Directed table-driven bench for register_file.
// Vectors apply one edge each; expected values are hand-computed.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  read_addr1;
  logic [3:0]  read_addr2;
  logic [3:0]  write_addr;
  logic [17:0] write_data;
  logic        write_enable;
  logic [17:0] write_data_in;
  logic [17:0] data_out1;
  logic [17:0] data_out2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_data_in(write_data_in),
    .data_out1    (data_out1),
    .data_out2    (data_out2)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  wa;
    logic [17:0] wd;
    logic [17:0] win;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [17:0] e1;
    logic [17:0] e2;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [17:0] act,
                     input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"r15_first", 1'b0, 4'd0,  18'h00000, 18'h00ABC,
                 4'd15, 4'd0, 18'h00ABC, 18'h00000};
    vecs[1]  = '{"wr_r3", 1'b1, 4'd3, 18'h0002A, 18'h00ABC,
                 4'd3, 4'd2, 18'h0002A, 18'h00000};
    vecs[2]  = '{"wr_r1", 1'b1, 4'd1, 18'h000A5, 18'h00ABC,
                 4'd1, 4'd0, 18'h000A5, 18'h00000};
    vecs[3]  = '{"we0_a", 1'b0, 4'd1, 18'h3FFFF, 18'h00ABC,
                 4'd1, 4'd3, 18'h000A5, 18'h0002A};
    vecs[4]  = '{"we0_b", 1'b0, 4'd1, 18'h3FFFF, 18'h00ABC,
                 4'd1, 4'd15, 18'h000A5, 18'h00ABC};
    vecs[5]  = '{"in_load", 1'b0, 4'd1, 18'h3FFFF, 18'h12345,
                 4'd15, 4'd1, 18'h12345, 18'h000A5};
    vecs[6]  = '{"in_prio", 1'b1, 4'd15, 18'h00777, 18'h2AAAA,
                 4'd15, 4'd15, 18'h00777, 18'h00777};
    vecs[7]  = '{"in_after", 1'b0, 4'd15, 18'h00777, 18'h2AAAA,
                 4'd15, 4'd3, 18'h2AAAA, 18'h0002A};
    vecs[8]  = '{"dual_r7", 1'b1, 4'd7, 18'h3FFFF, 18'h00000,
                 4'd7, 4'd7, 18'h3FFFF, 18'h3FFFF};
    vecs[9]  = '{"wr_r0", 1'b1, 4'd0, 18'h15555, 18'h00000,
                 4'd0, 4'd7, 18'h15555, 18'h3FFFF};
    vecs[10] = '{"wr_r14", 1'b1, 4'd14, 18'h20001, 18'h00000,
                 4'd14, 4'd13, 18'h20001, 18'h00000};

    rst_n = 1'b0;
    write_enable = 1'b1;
    write_addr = 4'd4;
    write_data = 18'h3FFFF;
    write_data_in = 18'h1FFFF;
    read_addr1 = 4'd0;
    read_addr2 = 4'd0;

    // Reset held two edges, with a write pending that must be dropped.
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) begin
      read_addr1 = 4'(a);
      read_addr2 = 4'(15 - a);
      #1;
      chk($sformatf("rst_p1_a%0d", a), data_out1, 18'h0);
      chk($sformatf("rst_p2_a%0d", 15 - a), data_out2, 18'h0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      write_enable = vecs[i].we;
      write_addr = vecs[i].wa;
      write_data = vecs[i].wd;
      write_data_in = vecs[i].win;
      read_addr1 = vecs[i].ra1;
      read_addr2 = vecs[i].ra2;
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_p1"}, data_out1, vecs[i].e1);
      chk({vecs[i].name, "_p2"}, data_out2, vecs[i].e2);
      @(negedge clk);
    end

    // No bypass: old value visible until the edge, new value after.
    write_enable = 1'b1;
    write_addr = 4'd5;
    write_data = 18'h0BEEF;
    read_addr1 = 4'd5;
    read_addr2 = 4'd3;
    #1;
    chk("nobyp_before", data_out1, 18'h00000);
    @(posedge clk);
    #1;
    chk("nobyp_after", data_out1, 18'h0BEEF);
    chk("nobyp_r3", data_out2, 18'h0002A);

    // Address change between edges propagates without a clock.
    @(negedge clk);
    write_enable = 1'b0;
    read_addr1 = 4'd9;
    read_addr2 = 4'd8;
    #1;
    chk("comb_r9", data_out1, 18'h0);
    read_addr1 = 4'd1;
    read_addr2 = 4'd14;
    #1;
    chk("comb_r1", data_out1, 18'h000A5);
    chk("comb_r14", data_out2, 18'h20001);

    // Reset beats a simultaneous write and the input path.
    @(negedge clk);
    rst_n = 1'b0;
    write_enable = 1'b1;
    write_addr = 4'd7;
    write_data = 18'h00001;
    write_data_in = 18'h3C3C3;
    read_addr1 = 4'd7;
    read_addr2 = 4'd15;
    #1;
    chk("pre_rst_r7", data_out1, 18'h3FFFF);
    @(posedge clk);
    #1;
    chk("rst_r7", data_out1, 18'h0);
    chk("rst_r15", data_out2, 18'h0);
    read_addr1 = 4'd0;
    read_addr2 = 4'd1;
    #1;
    chk("rst_r0", data_out1, 18'h0);
    chk("rst_r1", data_out2, 18'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
